// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle for the ID/EX pipeline register.
// slave is the pipeline register itself; master is the decode/hazard-facing driver side.
interface id_ex_stage_if #(
    parameter int DW = 64,
    parameter int CW = 16
);
    logic          IDValid;
    logic [DW-1:0] IDPC;
    logic [DW-1:0] IDReadData1;
    logic [DW-1:0] IDReadData2;
    logic [DW-1:0] IDSignExt;
    logic [10:0]   IDOPCode;
    logic [4:0]    IDRn;
    logic [4:0]    IDRm;
    logic [4:0]    IDRd;
    logic          IDReadsRm;
    logic [1:0]    IDALUOP;
    logic          IDALUSrc;
    logic          IDMemRead;
    logic          IDMemWrite;
    logic          IDMemtoReg;
    logic          IDRegWrite;
    logic          IDBranch;
    logic          Flush;

    logic          EXValid;
    logic [DW-1:0] EXPC;
    logic [DW-1:0] EXReadData1;
    logic [DW-1:0] EXReadData2;
    logic [DW-1:0] EXSignExt;
    logic [10:0]   OPCode;
    logic [1:0]    ALUOP;
    logic [4:0]    EXRn;
    logic [4:0]    EXRm;
    logic [4:0]    EXRd;
    logic          EXALUSrc;
    logic          EXMemRead;
    logic          EXMemWrite;
    logic          EXMemtoReg;
    logic          EXRegWrite;
    logic          EXBranch;
    logic          PCWrite;
    logic          IFIDWrite;
    logic [CW-1:0] BubbleCount;

    modport master (
        output IDValid, IDPC, IDReadData1, IDReadData2, IDSignExt, IDOPCode,
               IDRn, IDRm, IDRd, IDReadsRm, IDALUOP, IDALUSrc, IDMemRead,
               IDMemWrite, IDMemtoReg, IDRegWrite, IDBranch, Flush,
        input  EXValid, EXPC, EXReadData1, EXReadData2, EXSignExt, OPCode,
               ALUOP, EXRn, EXRm, EXRd, EXALUSrc, EXMemRead, EXMemWrite,
               EXMemtoReg, EXRegWrite, EXBranch, PCWrite, IFIDWrite, BubbleCount
    );

    modport slave (
        input  IDValid, IDPC, IDReadData1, IDReadData2, IDSignExt, IDOPCode,
               IDRn, IDRm, IDRd, IDReadsRm, IDALUOP, IDALUSrc, IDMemRead,
               IDMemWrite, IDMemtoReg, IDRegWrite, IDBranch, Flush,
        output EXValid, EXPC, EXReadData1, EXReadData2, EXSignExt, OPCode,
               ALUOP, EXRn, EXRm, EXRd, EXALUSrc, EXMemRead, EXMemWrite,
               EXMemtoReg, EXRegWrite, EXBranch, PCWrite, IFIDWrite, BubbleCount
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a
// saturating bubble counter. Advances every cycle; there is no enable.
module id_ex_stage #(
    parameter int         DW  = 64,
    parameter int         CW  = 16,
    parameter logic [4:0] XZR = 5'd31
) (
    input logic          CLOCK,
    input logic          RESET,
    id_ex_stage_if.slave bus
);
    // Handshake: IDValid marks a real instruction in decode and EXValid one in EX.
    // There is no ready; stalling is expressed only by PCWrite/IFIDWrite = 0, which
    // makes decode re-present the same instruction on the next cycle.
    logic hazard;
    logic bubble;
    logic kill;

    always_comb begin
        hazard = bus.EXValid & bus.EXMemRead & (bus.EXRd != XZR) & bus.IDValid &
                 ((bus.EXRd == bus.IDRn) | (bus.IDReadsRm & (bus.EXRd == bus.IDRm)));
        bubble = bus.Flush | hazard;
        kill   = bubble | ~bus.IDValid;
    end

    // A flushed instruction is discarded, so the front end must not hold it.
    assign bus.PCWrite   = ~(hazard & ~bus.Flush);
    assign bus.IFIDWrite = ~(hazard & ~bus.Flush);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            bus.EXValid     <= 1'b0;
            bus.EXPC        <= '0;
            bus.EXReadData1 <= '0;
            bus.EXReadData2 <= '0;
            bus.EXSignExt   <= '0;
            bus.OPCode      <= '0;
            bus.ALUOP       <= 2'b00;
            bus.EXRn        <= '0;
            bus.EXRm        <= '0;
            bus.EXRd        <= '0;
            bus.EXALUSrc    <= 1'b0;
            bus.EXMemRead   <= 1'b0;
            bus.EXMemWrite  <= 1'b0;
            bus.EXMemtoReg  <= 1'b0;
            bus.EXRegWrite  <= 1'b0;
            bus.EXBranch    <= 1'b0;
            bus.BubbleCount <= '0;
        end else begin
            // Data, index and OPCode fields load even into a bubble; only control is killed.
            bus.EXPC        <= bus.IDPC;
            bus.EXReadData1 <= bus.IDReadData1;
            bus.EXReadData2 <= bus.IDReadData2;
            bus.EXSignExt   <= bus.IDSignExt;
            bus.OPCode      <= bus.IDOPCode;
            bus.EXRn        <= bus.IDRn;
            bus.EXRm        <= bus.IDRm;
            bus.EXRd        <= bus.IDRd;
            bus.EXValid     <= bus.IDValid & ~bubble;
            bus.ALUOP       <= kill ? 2'b00 : bus.IDALUOP;
            bus.EXALUSrc    <= ~kill & bus.IDALUSrc;
            bus.EXMemRead   <= ~kill & bus.IDMemRead;
            bus.EXMemWrite  <= ~kill & bus.IDMemWrite;
            bus.EXMemtoReg  <= ~kill & bus.IDMemtoReg;
            bus.EXRegWrite  <= ~kill & bus.IDRegWrite;
            bus.EXBranch    <= ~kill & bus.IDBranch;
            if (bubble && (bus.BubbleCount != {CW{1'b1}})) begin
                bus.BubbleCount <= bus.BubbleCount + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load-use stalls, flush, streaming latency,
// asynchronous reset during a stall and bubble counter saturation (CW=4).
module tb_id_ex_stage;
    localparam int DW = 64;
    localparam int CW = 4;

    // ctrl packing: {ALUOP[1:0], ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, Branch}
    localparam logic [7:0]  C_LDUR = 8'b00_1_1_0_1_1_0;
    localparam logic [7:0]  C_RTYP = 8'b10_0_0_0_0_1_0;
    localparam logic [7:0]  C_STUR = 8'b00_1_0_1_0_0_0;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_pc;

    id_ex_stage_if #(.DW(DW), .CW(CW)) bus ();

    id_ex_stage #(.DW(DW), .CW(CW), .XZR(5'd31)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    logic [7:0] ex_ctrl;
    assign ex_ctrl = {bus.ALUOP, bus.EXALUSrc, bus.EXMemRead, bus.EXMemWrite,
                      bus.EXMemtoReg, bus.EXRegWrite, bus.EXBranch};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic valid, input logic [DW-1:0] pc,
                         input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                         input logic [DW-1:0] imm, input logic [10:0] opc,
                         input logic [4:0] rn, input logic [4:0] rm,
                         input logic [4:0] rd, input logic reads_rm,
                         input logic [7:0] ctrl);
        bus.IDValid     = valid;
        bus.IDPC        = pc;
        bus.IDReadData1 = rd1;
        bus.IDReadData2 = rd2;
        bus.IDSignExt   = imm;
        bus.IDOPCode    = opc;
        bus.IDRn        = rn;
        bus.IDRm        = rm;
        bus.IDRd        = rd;
        bus.IDReadsRm   = reads_rm;
        {bus.IDALUOP, bus.IDALUSrc, bus.IDMemRead, bus.IDMemWrite,
         bus.IDMemtoReg, bus.IDRegWrite, bus.IDBranch} = ctrl;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.Flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 1'b0, 8'h00);
        #12;
        check("rst_exvalid", {63'd0, bus.EXValid}, 64'd0);
        check("rst_ctrl", {56'd0, ex_ctrl}, 64'd0);
        check("rst_bubbles", {60'd0, bus.BubbleCount}, 64'd0);
        check("rst_pcwrite", {63'd0, bus.PCWrite}, 64'd1);
        check("rst_ifidwrite", {63'd0, bus.IFIDWrite}, 64'd1);
        rst = 1'b0;

        // LDUR X2,[X1,#8] then ADD X3,X2,X4
        drive(1'b1, 64'h10, 64'h100, 64'h0, 64'd8, OP_LDUR, 5'd1, 5'd0, 5'd2, 1'b0, C_LDUR);
        tick();
        check("ldur_valid", {63'd0, bus.EXValid}, 64'd1);
        check("ldur_ctrl", {56'd0, ex_ctrl}, {56'd0, C_LDUR});
        check("ldur_rd", {59'd0, bus.EXRd}, 64'd2);
        drive(1'b1, 64'h14, 64'h5, 64'h6, 64'd0, OP_ADD, 5'd2, 5'd4, 5'd3, 1'b1, C_RTYP);
        #1;
        check("lu_pcwrite", {63'd0, bus.PCWrite}, 64'd0);
        check("lu_ifidwrite", {63'd0, bus.IFIDWrite}, 64'd0);
        tick();
        check("lu_bubble_valid", {63'd0, bus.EXValid}, 64'd0);
        check("lu_bubble_ctrl", {56'd0, ex_ctrl}, 64'd0);
        check("lu_bubble_count", {60'd0, bus.BubbleCount}, 64'd1);
        check("lu_released", {63'd0, bus.PCWrite}, 64'd1);
        tick();
        check("lu_add_valid", {63'd0, bus.EXValid}, 64'd1);
        check("lu_add_aluop", {62'd0, bus.ALUOP}, 64'd2);
        check("lu_add_opcode", {53'd0, bus.OPCode}, {53'd0, OP_ADD});
        check("lu_add_pc", bus.EXPC, 64'h14);
        check("lu_add_count", {60'd0, bus.BubbleCount}, 64'd1);

        // LDUR into XZR never stalls
        drive(1'b1, 64'h18, 64'h0, 64'h0, 64'd0, OP_LDUR, 5'd1, 5'd0, 5'd31, 1'b0, C_LDUR);
        tick();
        drive(1'b1, 64'h1c, 64'h0, 64'h0, 64'd0, OP_ADD, 5'd31, 5'd31, 5'd3, 1'b1, C_RTYP);
        #1;
        check("xzr_pcwrite", {63'd0, bus.PCWrite}, 64'd1);
        tick();
        check("xzr_valid", {63'd0, bus.EXValid}, 64'd1);
        // Rm match ignored when the second port is unused
        drive(1'b1, 64'h20, 64'h0, 64'h0, 64'd0, OP_LDUR, 5'd1, 5'd0, 5'd5, 1'b0, C_LDUR);
        tick();
        drive(1'b1, 64'h24, 64'h0, 64'h0, 64'd0, OP_ADD, 5'd7, 5'd5, 5'd6, 1'b0, C_RTYP);
        #1;
        check("norm_pcwrite", {63'd0, bus.PCWrite}, 64'd1);
        tick();
        check("norm_valid", {63'd0, bus.EXValid}, 64'd1);
        // Rm match counts when the second port is used
        drive(1'b1, 64'h28, 64'h0, 64'h0, 64'd0, OP_LDUR, 5'd1, 5'd0, 5'd5, 1'b0, C_LDUR);
        tick();
        drive(1'b1, 64'h2c, 64'h0, 64'h0, 64'd0, OP_ADD, 5'd9, 5'd5, 5'd8, 1'b1, C_RTYP);
        #1;
        check("rm_pcwrite", {63'd0, bus.PCWrite}, 64'd0);
        tick();
        check("rm_bubble_valid", {63'd0, bus.EXValid}, 64'd0);
        check("rm_bubble_count", {60'd0, bus.BubbleCount}, 64'd2);
        tick();
        check("rm_add_valid", {63'd0, bus.EXValid}, 64'd1);

        // Flush kills a valid SUB
        drive(1'b1, 64'h30, 64'h9, 64'h4, 64'd0, OP_SUB, 5'd1, 5'd2, 5'd3, 1'b1, C_RTYP);
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        check("fl_valid", {63'd0, bus.EXValid}, 64'd0);
        check("fl_aluop", {62'd0, bus.ALUOP}, 64'd0);
        check("fl_regwrite", {63'd0, bus.EXRegWrite}, 64'd0);
        check("fl_count", {60'd0, bus.BubbleCount}, 64'd3);
        // Flush together with a hazard
        drive(1'b1, 64'h34, 64'h0, 64'h0, 64'd0, OP_LDUR, 5'd1, 5'd0, 5'd9, 1'b0, C_LDUR);
        tick();
        drive(1'b1, 64'h38, 64'h0, 64'h0, 64'd0, OP_ADD, 5'd9, 5'd1, 5'd4, 1'b1, C_RTYP);
        bus.Flush = 1'b1;
        #1;
        check("flhz_pcwrite", {63'd0, bus.PCWrite}, 64'd1);
        check("flhz_ifidwrite", {63'd0, bus.IFIDWrite}, 64'd1);
        tick();
        bus.Flush = 1'b0;
        check("flhz_valid", {63'd0, bus.EXValid}, 64'd0);
        check("flhz_count", {60'd0, bus.BubbleCount}, 64'd4);

        // ADD / ORR / STUR stream: one-cycle latency
        drive(1'b1, 64'h40, 64'h11, 64'h22, 64'hFFFF_FFFF_FFFF_FFF8, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b1, C_RTYP);
        exp_q.push_back(64'h40);
        tick();
        exp_pc = exp_q.pop_front();
        check("st_add_pc", bus.EXPC, exp_pc);
        check("st_add_imm", bus.EXSignExt, 64'hFFFF_FFFF_FFFF_FFF8);
        check("st_add_rd1", bus.EXReadData1, 64'h11);
        check("st_add_rd2", bus.EXReadData2, 64'h22);
        check("st_add_idx", {49'd0, bus.EXRn, bus.EXRm, bus.EXRd}, {49'd0, 5'd1, 5'd2, 5'd3});
        drive(1'b1, 64'h44, 64'h33, 64'h44, 64'd0, OP_ORR, 5'd3, 5'd4, 5'd5, 1'b1, C_RTYP);
        exp_q.push_back(64'h44);
        #1;
        check("st_hold_pc", bus.EXPC, 64'h40);
        tick();
        exp_pc = exp_q.pop_front();
        check("st_orr_pc", bus.EXPC, exp_pc);
        check("st_orr_opcode", {53'd0, bus.OPCode}, {53'd0, OP_ORR});
        drive(1'b1, 64'h48, 64'h50, 64'h66, 64'd16, OP_STUR, 5'd5, 5'd6, 5'd6, 1'b1, C_STUR);
        exp_q.push_back(64'h48);
        tick();
        exp_pc = exp_q.pop_front();
        check("st_stur_pc", bus.EXPC, exp_pc);
        check("st_stur_ctrl", {56'd0, ex_ctrl}, {56'd0, C_STUR});
        check("st_stur_imm", bus.EXSignExt, 64'd16);
        check("st_count", {60'd0, bus.BubbleCount}, 64'd4);

        // Asynchronous reset in the middle of a stall
        drive(1'b1, 64'h50, 64'h0, 64'h0, 64'd0, OP_LDUR, 5'd1, 5'd0, 5'd2, 1'b0, C_LDUR);
        tick();
        drive(1'b1, 64'h54, 64'h7, 64'h8, 64'd0, OP_ADD, 5'd2, 5'd4, 5'd3, 1'b1, C_RTYP);
        #1;
        check("ar_stall", {63'd0, bus.PCWrite}, 64'd0);
        rst = 1'b1;
        #1;
        check("ar_valid", {63'd0, bus.EXValid}, 64'd0);
        check("ar_ctrl", {56'd0, ex_ctrl}, 64'd0);
        check("ar_pc", bus.EXPC, 64'd0);
        check("ar_count", {60'd0, bus.BubbleCount}, 64'd0);
        check("ar_pcwrite", {63'd0, bus.PCWrite}, 64'd1);
        rst = 1'b0;
        tick();
        check("ar_reload_valid", {63'd0, bus.EXValid}, 64'd1);
        check("ar_reload_pc", bus.EXPC, 64'h54);
        check("ar_reload_ctrl", {56'd0, ex_ctrl}, {56'd0, C_RTYP});
        check("ar_reload_count", {60'd0, bus.BubbleCount}, 64'd0);

        // 20 consecutive flush bubbles saturate a 4-bit counter
        bus.Flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) check("sat_14", {60'd0, bus.BubbleCount}, 64'd14);
        end
        bus.Flush = 1'b0;
        check("sat_15", {60'd0, bus.BubbleCount}, 64'd15);
        tick();
        check("sat_hold", {60'd0, bus.BubbleCount}, 64'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
